demux_1to6_stream: RTL
======================

# demux_1to6_stream

Framed 1-to-6 stream demultiplexer for the signal-generator test path: the distribution-side counterpart of the 6-way source selector. Accepts one valid/ready sample stream and routes each frame of FRAME_LEN samples to one of six output channels. The channel is chosen by a select value latched at frame start. A single-entry registered output stage gives full throughput with one cycle of latency.

## Interface
- WIDTH, default 5: sample data width.
- FRAME_LEN, default 16: samples per frame. Legal range is 1 or more. The select value is re-latched only at frame boundaries.
- clk  input  1  single system clock; everything is rising-edge.
- rst_n  input  1  asynchronous, active-low reset.
- s_data  input  WIDTH  input sample.
- s_valid  input  1  input sample valid.
- s_ready  output  1  block accepts the sample this cycle.
- sel_req  input  3  requested channel, 0..5. Sampled only at frame start.
- out0..out5  output  WIDTH each  channel data. Equals the held sample when that channel's valid is high, else 0.
- out_valid  output  6  one-hot per-channel valid.
- out_ready  input  6  per-channel ready from the consumers.
- active_sel  output  3  channel latched for the current frame. Holds its last value in IDLE.
- sel_err  output  1  one-cycle pulse: an out-of-range select was latched.

## Operation
- Handshake: a transfer occurs when valid and ready are both high on the same clock edge. Data is held stable while valid is high and ready is low.
- FSM states are IDLE and RUN.
  - IDLE: frame counter is 0. The first accepted sample latches sel_req into active_sel, counts as sample 1, and moves the FSM to RUN. If FRAME_LEN=1, the FSM stays in IDLE.
  - RUN: each accepted sample increments the counter. Accepting sample FRAME_LEN returns the FSM to IDLE with the counter at 0.
- sel_req changes during RUN are ignored.
- Drop mode: if the latched select is 6 or 7, every sample of that frame is accepted (s_ready=1) and discarded. Dropped samples still count toward the frame and never load the output stage. sel_err pulses high for the cycle after the latching transfer.
- Output stage holds one entry: {full, tag[2:0], data}.
  - tag is the channel of the held sample, so a frame boundary never re-routes already-held data.
  - out_valid[k] = full && tag==k.
  - s_ready = !full || out_ready[tag], or 1 in drop mode.
  - When a load and an unload happen in the same cycle, the new sample replaces the old one and full stays 1.
  - Unload with no load clears full.
- The first sample of a new frame can load on the same edge that the last sample of the previous frame unloads, even when the two target different channels.

## Timing
- Reset values: full=0, tag=0, data=0, out0..out5=0, out_valid=0, active_sel=0, sel_err=0, state IDLE, counter 0. s_ready=1 after reset, since it is combinational from !full.
- Latency is 1 cycle: a sample accepted at edge N is presented from after edge N on out_valid[tag].
- Throughput is 1 sample/cycle while the target consumer holds out_ready high. Drop mode always runs at 1 sample/cycle.
- s_ready depends combinationally on out_ready[tag]. No other input-to-output combinational paths.
- Asserting rst_n low mid-frame discards the held sample and the frame count immediately. The next frame starts by re-latching sel_req.
- Counter width is $clog2(FRAME_LEN+1). The counter wraps to 0 at the end of each frame, never past FRAME_LEN.

## Structure
- Package demux_pkg holds:
  - NUM_CH=6 and SEL_W=3.
  - The state enum {IDLE, RUN}.
  - A function sel_valid(sel) returning sel < NUM_CH.
- Sub-module stream_reg_slice, parameterised on payload width. It holds the single-entry valid/ready register with the replace-on-simultaneous rule, carrying {tag, data}.
- The top level contains the FSM, the frame counter, drop-mode logic and the one-hot decode of out_valid and out0..out5.

## Test plan
- Reset, then sel_req=2, 16 samples 1..16 back-to-back with out_ready=all 1 → out2 shows 1..16 on consecutive cycles, each one cycle after acceptance; the other five valids stay 0; s_ready stays 1.
- sel_req=2 for frame A, then sel_req changed to 4 at sample 5 of frame A → frame A stays entirely on channel 2. Frame B goes to channel 4. Frame B's first sample loads on the edge frame A's last sample unloads, with no bubble.
- Channel 3 with out_ready[3]=0 for 5 cycles mid-frame → s_ready=0; out3 and out_valid[3] hold stable; no sample is lost or duplicated; the counter pauses.
- sel_req=7 at frame start → sel_err pulses once. All 16 samples are accepted with s_ready=1. out_valid stays 0. The next frame with sel_req=0 routes normally.
- Assert rst_n low asynchronously after 7 samples on channel 1 → all outputs are 0 immediately. After release, sel_req=5 plus 16 samples route entirely to out5.
- FRAME_LEN=1 build, sel_req alternating 0,1,0,1 per sample → routing alternates every sample at full throughput.

Source files
------------

// File: rtl/demux_1to6_stream_pkg.sv
// demux_pkg: shared channel count, select width, FSM states and select range check
package demux_pkg;
  localparam int NUM_CH = 6;
  localparam int SEL_W = 3;
  typedef enum logic {IDLE, RUN} state_t;
  function automatic logic sel_valid(input logic [SEL_W-1:0] sel);
    return int'(sel) < NUM_CH;
  endfunction
endpackage

// File: rtl/demux_1to6_stream_if.sv
// demux_1to6_stream_if: stream in (s_data/s_valid/s_ready, sel_req), six channel outs (out0..out5, out_valid, out_ready), status (active_sel, sel_err)
interface demux_1to6_stream_if #(parameter int WIDTH = 5);
  logic [WIDTH-1:0] s_data;
  logic s_valid;
  logic s_ready;
  logic [2:0] sel_req;
  logic [WIDTH-1:0] out0, out1, out2, out3, out4, out5;
  logic [5:0] out_valid;
  logic [5:0] out_ready;
  logic [2:0] active_sel;
  logic sel_err;
  modport master (
    output s_data, s_valid, sel_req, out_ready,
    input s_ready, out0, out1, out2, out3, out4, out5, out_valid, active_sel, sel_err
  );
  modport slave (
    input s_data, s_valid, sel_req, out_ready,
    output s_ready, out0, out1, out2, out3, out4, out5, out_valid, active_sel, sel_err
  );
endinterface

// File: rtl/demux_1to6_stream_reg_slice.sv
// stream_reg_slice: single-entry valid/ready register; ports clk, rst_n, in_valid_i/in_data_i/in_ready_o, out_valid_o/out_data_o/out_ready_i; a simultaneous load and unload replaces the entry
module stream_reg_slice #(parameter int W = 8) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid_i,
  input  logic [W-1:0] in_data_i,
  output logic         in_ready_o,
  output logic         out_valid_o,
  output logic [W-1:0] out_data_o,
  input  logic         out_ready_i
);
  logic full_q;
  logic [W-1:0] data_q;
  assign in_ready_o = !full_q || out_ready_i;
  assign out_valid_o = full_q;
  assign out_data_o = data_q;
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      full_q <= 1'b0;
      data_q <= '0;
    end else if (in_valid_i && in_ready_o) begin
      full_q <= 1'b1;
      data_q <= in_data_i;
    end else if (out_ready_i) begin
      full_q <= 1'b0;
    end
endmodule

// File: rtl/demux_1to6_stream.sv
// demux_1to6_stream: routes FRAME_LEN-sample frames from one valid/ready stream to one of six channels chosen at frame start; ports clk, rst_n, bus (slave)
module demux_1to6_stream
  import demux_pkg::*;
#(
  parameter int WIDTH = 5,
  parameter int FRAME_LEN = 16
) (
  input logic clk,
  input logic rst_n,
  demux_1to6_stream_if.slave bus
);
  localparam int CW = $clog2(FRAME_LEN + 1);
  localparam int PW = SEL_W + WIDTH;
  state_t state_q;
  logic [CW-1:0] cnt_q;
  logic [SEL_W-1:0] active_sel_q;
  logic sel_err_q;
  logic [SEL_W-1:0] cur_sel, tag;
  logic [WIDTH-1:0] data;
  logic [PW-1:0] held;
  logic [7:0] ordy_ext;
  logic drop, slice_ready, full, xfer, last;
  assign cur_sel = state_q == IDLE ? bus.sel_req : active_sel_q;
  assign drop = !sel_valid(cur_sel);
  assign bus.s_ready = drop || slice_ready;
  assign xfer = bus.s_valid && bus.s_ready;
  assign last = cnt_q == CW'(FRAME_LEN - 1);
  assign {tag, data} = held;
  assign ordy_ext = {2'b00, bus.out_ready};
  stream_reg_slice #(.W(PW)) u_slice (
    .clk(clk),
    .rst_n(rst_n),
    .in_valid_i(bus.s_valid && !drop),
    .in_data_i({cur_sel, bus.s_data}),
    .in_ready_o(slice_ready),
    .out_valid_o(full),
    .out_data_o(held),
    .out_ready_i(ordy_ext[tag])
  );
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q <= '0;
      active_sel_q <= '0;
      sel_err_q <= 1'b0;
    end else begin
      sel_err_q <= xfer && state_q == IDLE && !sel_valid(bus.sel_req);
      if (xfer && state_q == IDLE) begin
        active_sel_q <= bus.sel_req;
        state_q <= FRAME_LEN == 1 ? IDLE : RUN;
        cnt_q <= FRAME_LEN == 1 ? '0 : CW'(1);
      end else if (xfer) begin
        state_q <= last ? IDLE : RUN;
        cnt_q <= last ? '0 : cnt_q + CW'(1);
      end
    end
  for (genvar k = 0; k < NUM_CH; k++) begin : g_vld
    assign bus.out_valid[k] = full && tag == SEL_W'(k);
  end
  assign bus.out0 = bus.out_valid[0] ? data : '0;
  assign bus.out1 = bus.out_valid[1] ? data : '0;
  assign bus.out2 = bus.out_valid[2] ? data : '0;
  assign bus.out3 = bus.out_valid[3] ? data : '0;
  assign bus.out4 = bus.out_valid[4] ? data : '0;
  assign bus.out5 = bus.out_valid[5] ? data : '0;
  assign bus.active_sel = active_sel_q;
  assign bus.sel_err = sel_err_q;
endmodule
